// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: conditions ps2_clk/ps2_data, deserialises 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events in a show-ahead FIFO.
// The break flag port is named 'released' because 'release' is a reserved word.
`timescale 1ns/1ps
module ps2_host_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FIFO_AW        = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] code,
  output logic       ext,
  output logic       released,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       rx_active
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int FCW   = $clog2(FILTER_LEN) + 1;
  localparam int TCW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  // Stage p0/p1: two-flop synchronisers
  logic ps2_clk_p0, ps2_clk_p1, ps2_data_p0, ps2_data_p1;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Glitch filter on the synchronised clock
  logic           filt, filt_d, fall;
  logic [FCW-1:0] flt_cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (ps2_clk_p1 != filt) begin
        if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
          filt    <= ~filt;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FCW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // Frame FSM
  state_t         state, state_nx;
  logic [2:0]     bit_cnt, bit_cnt_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           par_bit, par_nx;
  logic           deliver_nx, perr_nx, ferr_nx;
  logic [TCW-1:0] tcnt;
  logic           timeout;

  assign timeout   = (state != IDLE) && !fall && (tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign rx_active = (state != IDLE);

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    deliver_nx = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    if (timeout) begin
      state_nx = IDLE;
      ferr_nx  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!ps2_data_p1) begin
            state_nx   = DATA;
            bit_cnt_nx = 3'd0;
          end
        end
        DATA: begin
          shreg_nx[bit_cnt] = ps2_data_p1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
          else bit_cnt_nx = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_nx   = ps2_data_p1;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!ps2_data_p1) ferr_nx = 1'b1;
          else if (!parity_ok(shreg, par_bit)) perr_nx = 1'b1;
          else deliver_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic [7:0] rx_byte_p2;
  logic       vld_p2;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      tcnt       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      parity_err <= perr_nx;
      frame_err  <= ferr_nx;
      vld_p2     <= deliver_nx;
      if (state == IDLE || fall) tcnt <= '0;
      else tcnt <= tcnt + TCW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    shreg   <= shreg_nx;
    par_bit <= par_nx;
    if (deliver_nx) rx_byte_p2 <= shreg;
  end

  // Stage p2: prefix folding and event FIFO
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_nx;
  logic               ext_pend, rel_pend;
  logic               is_prefix, push, pop, full, push_ok;
  logic [9:0]         head;

  assign is_prefix = (rx_byte_p2 == PFX_EXT) || (rx_byte_p2 == PFX_BRK);
  assign push      = vld_p2 && !is_prefix;
  assign valid     = (count != '0);
  assign pop       = rd && valid;
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = push && (!full || pop);

  always_comb begin
    count_nx = count;
    case ({push_ok, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      count    <= count_nx;
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (parity_err || frame_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (vld_p2) begin
        if (rx_byte_p2 == PFX_EXT) ext_pend <= 1'b1;
        else if (rx_byte_p2 == PFX_BRK) rel_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= {ext_pend, rel_pend, rx_byte_p2};
  end

  // Head fields read as zero while the queue is empty
  assign head     = mem[rd_ptr];
  assign code     = valid ? head[7:0] : 8'h00;
  assign ext      = valid & head[9];
  assign released = valid & head[8];

endmodule

// File: tb/tb_ps2_host_rx.sv
// Bench for ps2_host_rx: table vectors, hand-written corner sequences and a
// randomized run against a queue-based event model. clk_sys = 1 MHz, bit period 40 us.
`timescale 1ns/1ps
module tb_ps2_host_rx;

  localparam int HALF = 20;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic       valid, ext, released, parity_err, frame_err, overflow, rx_active;
  logic [7:0] code;

  ps2_host_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(4096), .FIFO_AW(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd(rd), .valid(valid), .code(code), .ext(ext), .released(released),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .rx_active(rx_active)
  );

  always #500 clk_sys = ~clk_sys;

  int n_chk = 0, n_err = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;

  always @(negedge clk_sys) begin
    if (parity_err === 1'b1) perr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #150_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] b;
    bit pf; bit sb;
    bit evt; logic [7:0] c; bit e; bit r;
    bit pe; bit fe;
  } tv_t;

  tv_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pf, input bit sb);
    logic par;
    par = ~(^b) ^ pf;
    return {~sb, par, b, 1'b0};
  endfunction

  // Drives the first nbits of a frame; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pf, input bit sb, input bit glitch);
    send_bits(mk_frame(b, pf, sb), 11, glitch);
    ps2_data = 1'b1;
    wait_cyc(5);
  endtask

  // Stop-bit phase with timing hooks. Raw fall -> 2 sync + 8 filter edges to the
  // filtered fall, +2 edges to valid: valid is seen after the 12th posedge.
  task automatic stop_phase(input bit rd_at_push, input bit lat_chk);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    for (int k = 1; k <= HALF; k++) begin
      wait_cyc(1);
      if (lat_chk && k == 11) chk("latency_valid_before", valid, 1'b0);
      if (lat_chk && k == 12) chk("latency_valid_at", valid, 1'b1);
      if (rd_at_push) rd = (k == 11);
    end
    rd = 1'b0;
    ps2_clk = 1'b1;
    wait_cyc(5);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] c, input bit e, input bit r);
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_code"}, code, c);
    chk({tag, "_ext"}, ext, e);
    chk({tag, "_rel"}, released, r);
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
  endtask

  int pb, fb, ob, t;
  logic [7:0] rb;
  bit rpf, rsb, m_ext, m_rel;
  int m_perr, m_ferr, m_ovf;
  logic [9:0] q[$];
  logic [9:0] hd;

  initial begin
    tv[0]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[1]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[2]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0, 0};
    tv[3]  = '{8'h75, 0, 0, 1, 8'h75, 0, 0, 0, 0};
    tv[4]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1, 0};
    tv[5]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[6]  = '{8'h1C, 0, 1, 0, 8'h00, 0, 0, 0, 1};
    tv[7]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 0};
    tv[8]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[9]  = '{8'hE1, 0, 0, 1, 8'hE1, 1, 0, 0, 0};
    tv[10] = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[11] = '{8'h14, 0, 0, 1, 8'h14, 0, 1, 0, 0};
    tv[12] = '{8'hE0, 1, 1, 0, 8'h00, 0, 0, 0, 1};
    tv[13] = '{8'h6B, 0, 0, 1, 8'h6B, 0, 0, 0, 0};

    // Reset state
    wait_cyc(5);
    chk("rst_valid", valid, 1'b0);
    chk("rst_code", code, 8'h00);
    chk("rst_ext", ext, 1'b0);
    chk("rst_rel", released, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_active", rx_active, 1'b0);
    reset_n = 1'b1;
    wait_cyc(30);

    // Single frame with latency check
    send_bits(mk_frame(8'h1C, 0, 0), 10, 0);
    stop_phase(0, 1);
    pop_chk("lat", 8'h1C, 0, 0);
    chk("lat_empty", valid, 1'b0);

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      pb = perr_cnt;
      fb = ferr_cnt;
      send_frame(tv[i].b, tv[i].pf, tv[i].sb, 0);
      chk($sformatf("tv%0d_perr", i), perr_cnt - pb, tv[i].pe);
      chk($sformatf("tv%0d_ferr", i), ferr_cnt - fb, tv[i].fe);
      chk($sformatf("tv%0d_valid", i), valid, tv[i].evt);
      if (tv[i].evt) pop_chk($sformatf("tv%0d", i), tv[i].c, tv[i].e, tv[i].r);
    end

    // Glitches in idle and between bits
    pb = perr_cnt;
    fb = ferr_cnt;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(HALF);
    chk("glitch_idle_active", rx_active, 1'b0);
    send_frame(8'h5A, 0, 0, 1);
    chk("glitch_perr", perr_cnt - pb, 0);
    chk("glitch_ferr", ferr_cnt - fb, 0);
    pop_chk("glitch", 8'h5A, 0, 0);
    chk("glitch_empty", valid, 1'b0);

    // Timeout after 4 data bits
    send_bits(mk_frame(8'hA5, 0, 0), 5, 0);
    chk("to_active", rx_active, 1'b1);
    fb = ferr_cnt;
    t = 0;
    while (ferr_cnt == fb && t < 5000) begin
      wait_cyc(1);
      t++;
    end
    chk("to_fired", ferr_cnt - fb, 1);
    chk("to_window", (t >= 4000 && t <= 4200), 1'b1);
    wait_cyc(2);
    chk("to_idle", rx_active, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(10);
    send_frame(8'h29, 0, 0, 0);
    pop_chk("to_next", 8'h29, 0, 0);

    // Overflow: fifth event dropped
    ob = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
    chk("ovf_pulse", ovf_cnt - ob, 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'(i), 0, 0);
    chk("ovf_empty", valid, 1'b0);

    // Push and pop in the same cycle while full
    ob = ovf_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 0, 0);
    send_bits(mk_frame(8'h05, 0, 0), 10, 0);
    stop_phase(1, 0);
    chk("pp_no_ovf", ovf_cnt - ob, 0);
    for (int i = 2; i <= 5; i++) pop_chk($sformatf("pp_pop%0d", i), 8'(i), 0, 0);
    chk("pp_empty", valid, 1'b0);

    // Randomized frames against the event model
    pb = perr_cnt; fb = ferr_cnt; ob = ovf_cnt;
    m_perr = 0; m_ferr = 0; m_ovf = 0; m_ext = 0; m_rel = 0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hE1;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      t = $urandom_range(0, 9);
      rpf = (t == 0);
      rsb = (t == 1);
      send_frame(rb, rpf, rsb, 0);
      if (rsb) begin
        m_ferr++; m_ext = 0; m_rel = 0;
      end else if (rpf) begin
        m_perr++; m_ext = 0; m_rel = 0;
      end else if (rb == 8'hE0) m_ext = 1;
      else if (rb == 8'hF0) m_rel = 1;
      else begin
        if (q.size() == 4) m_ovf++;
        else q.push_back({m_ext, m_rel, rb});
        m_ext = 0; m_rel = 0;
      end
      chk($sformatf("rnd%0d_perr", n), perr_cnt - pb, m_perr);
      chk($sformatf("rnd%0d_ferr", n), ferr_cnt - fb, m_ferr);
      chk($sformatf("rnd%0d_ovf", n), ovf_cnt - ob, m_ovf);
      chk($sformatf("rnd%0d_valid", n), valid, q.size() != 0);
      if (q.size() != 0 && $urandom_range(0, 2) != 0) begin
        hd = q.pop_front();
        pop_chk($sformatf("rnd%0d", n), hd[7:0], hd[9], hd[8]);
      end
    end
    while (q.size() != 0) begin
      hd = q.pop_front();
      pop_chk("rnd_drain", hd[7:0], hd[9], hd[8]);
    end
    chk("rnd_empty", valid, 1'b0);

    // Mid-frame reset discards the frame silently
    pb = perr_cnt;
    fb = ferr_cnt;
    send_bits(mk_frame(8'h3C, 0, 0), 6, 0);
    reset_n = 1'b0;
    wait_cyc(2);
    chk("mrst_active", rx_active, 1'b0);
    reset_n = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4300);
    chk("mrst_perr", perr_cnt - pb, 0);
    chk("mrst_ferr", ferr_cnt - fb, 0);
    chk("mrst_valid", valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- PS/2 host-side receiver for the keyboard link driven by the MiST I/O controller (the controller acts as the PS/2 device and transmits; this block receives).
- Filters and deserialises 11-bit PS/2 frames and checks parity.
- Folds E0/F0 prefixes into flags and queues decoded key events in a small show-ahead FIFO for the keyboard matrix logic.
- Runs entirely in the clk_sys domain.

Parameters:
- FILTER_LEN, 8, consecutive identical clk_sys samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 4096, clk_sys cycles without a filtered falling edge before a partial frame is abandoned.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (4).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- ps2_clk  in  1  PS/2 clock line, asynchronous.
- ps2_data  in  1  PS/2 data line, asynchronous.
- rd  in  1  pop strobe; honoured only while valid=1.
- valid  out  1  FIFO non-empty.
- code  out  8  scancode at FIFO head.
- ext  out  1  head event was preceded by E0.
- release  out  1  head event was preceded by F0 (break).
- parity_err  out  1  one-cycle pulse on parity failure.
- frame_err  out  1  one-cycle pulse on bad stop bit or timeout.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- rx_active  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge): FSM to IDLE; FIFO emptied; prefix flags cleared; filter state set to 1; all outputs 0 (code, ext and release read 0 while empty).
- Input conditioning:
  - Two-flop synchroniser on both lines.
  - Filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - A fall event is a 1->0 transition of the filtered clock.
  - Data is sampled from the synchronised ps2_data in the same cycle as the fall event.
- FSM states and transitions:
  - IDLE: on fall with data=0 -> DATA, bit count 0. On fall with data=1, ignore and stay IDLE.
  - DATA: each fall shifts data into bit[count], LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on fall, the frame is good if data=1 and the XOR of 8 data bits and the parity bit is 1 (odd parity).
    - Good frame -> deliver the byte.
    - Parity bad -> parity_err pulse.
    - Stop bit 0 -> frame_err pulse (takes precedence if both are bad).
    - Always -> IDLE.
  - Timeout: in any state except IDLE, a counter counts clk_sys cycles since the last fall and resets on each fall. Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial byte discarded.
- Byte delivery, in the cycle after the STOP fall:
  - E0: set ext_pend.
  - F0: set rel_pend.
  - Any other byte, including E1: push {ext_pend, rel_pend, byte}, then clear both flags.
  - Any parity or frame error also clears both flags.
- Latency: valid rises 2 clk_sys cycles after the fall event of the stop bit.
- FIFO:
  - Show-ahead: head fields are valid whenever valid=1.
  - rd while valid=1 pops at the clock edge.
  - rd while empty is ignored.
  - Push while full with no pop: event dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle: both succeed, occupancy unchanged, including when full.
  - Pointers wrap modulo depth.
- Mid-frame reset: frame discarded, no error pulses.

Test Plan:
- Send frame for 0x1C (parity 0, stop 1) with 40 us bit period -> one event code=0x1C, ext=0, release=0; valid 2 cycles after the stop fall; rd -> valid=0.
- Send E0, F0, 0x75 -> exactly one event code=0x75, ext=1, release=1. Follow with 0x75 -> ext=0, release=0.
- Send 0x1C with parity bit 1 -> parity_err one pulse, no event. Send F0 then a bad-stop 0x1C -> frame_err, then a good 0x1C gives release=0.
- Stop ps2_clk after 4 data bits -> frame_err at TIMEOUT_CYCLES and rx_active=0. A following good 0x29 frame -> code=0x29.
- Inject 3-cycle low glitches on ps2_clk during IDLE and between bits -> no extra bits; the received byte is correct.
- Send 5 bytes (0x01 to 0x05) without rd -> the 5th is dropped with an overflow pulse; pops return 0x01 to 0x04. Assert rd in the same cycle as a push while full -> no overflow, ordering preserved.
